// File: rtl/mips_pkg.sv
// Shared constants for the MIPS-like core: opcodes the fetch unit acts on, the halt word
// and the run-control state encoding.
package mips_pkg;

    localparam logic [5:0]  OP_BEQ    = 6'b000100;
    localparam logic [5:0]  OP_J      = 6'b000010;
    localparam logic [5:0]  OP_JAL    = 6'b000011;
    localparam logic [5:0]  OP_JR     = 6'b001000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalt
    } state_e;

endpackage

// File: rtl/npc.sv
// Next-PC selection for the fetch unit: sequential, beq, j/jal and jr targets.
// Purely combinational; range checking is left to the caller.
module npc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] pc_plus4;
    logic [31:0] br_off;

    assign pc_plus4 = pc + 32'd4;
    assign br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        unique case (instr[31:26])
            OP_BEQ:       next_pc = zero ? (pc_plus4 + br_off) : pc_plus4;
            OP_J, OP_JAL: next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
            OP_JR:        next_pc = rs_data;
            default:      next_pc = pc_plus4;
        endcase
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: PC register, word-addressed instruction memory with a load port,
// and the IDLE/RUN/HALT run-control FSM with a sticky fault flag.
module ifetch
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              zero,
    input  logic [31:0]       rs_data,
    output logic [31:0]       instr,
    output logic [31:0]       pc,
    output logic [31:0]       link_addr,
    output logic              running,
    output logic              halted,
    output logic              fault
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fault_q, fault_d;
    logic [31:0] mem_q [DEPTH];
    logic [31:0] next_pc;
    logic        misaligned;
    logic        out_of_range;
    logic        load_ok;

    npc u_npc (
        .pc         (pc_q),
        .instr      (instr),
        .zero       (zero),
        .rs_data    (rs_data),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    // DEPTH is a power of two, so any set bit above the word index is out of range.
    assign out_of_range = |next_pc[31:ADDR_W+2];
    assign load_ok      = load_en && (state_q != StRun);

    assign instr     = (state_q == StRun) ? mem_q[pc_q[ADDR_W+1:2]] : 32'h0;
    assign pc        = pc_q;
    assign link_addr = pc_q + 32'd4;
    assign running   = (state_q == StRun);
    assign halted    = (state_q == StHalt);
    assign fault     = fault_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        unique case (state_q)
            StIdle, StHalt: begin
                // A simultaneous load wins over start.
                if (start && !load_en) begin
                    state_d = StRun;
                    pc_d    = RESET_PC;
                    fault_d = 1'b0;
                end
            end
            StRun: begin
                if (instr == HALT_WORD) begin
                    state_d = StHalt;
                end else if (!stall) begin
                    if (misaligned || out_of_range) begin
                        state_d = StHalt;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    // Program storage is deliberately outside reset.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem_q[load_addr] <= load_data;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: program load, sequential fetch, branches, jumps, stall,
// faults and mid-run reset, each against hand-computed values.
module tb_ifetch;

    localparam logic [31:0] ADD_W  = 32'h0000_0020;
    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
    localparam logic [31:0] BEQ_W  = 32'h1000_FFFE; // beq, imm -2
    localparam logic [31:0] JAL_W  = 32'h0C00_0020; // jal to 0x80
    localparam logic [31:0] JR_W   = 32'h2000_0000;
    localparam logic [31:0] J300_W = 32'h0800_012C; // j to word 300
    localparam logic [31:0] J20_W  = 32'h0800_0008; // j to 0x20

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        load_en = 1'b0;
    logic [7:0]  load_addr = 8'h0;
    logic [31:0] load_data = 32'h0;
    logic        zero = 1'b0;
    logic [31:0] rs_data = 32'h0;
    logic [31:0] instr, pc, link_addr;
    logic        running, halted, fault;

    int n_cmp = 0;
    int n_bad = 0;

    ifetch #(
        .DEPTH    (256),
        .ADDR_W   (8),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stall     (stall),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .zero      (zero),
        .rs_data   (rs_data),
        .instr     (instr),
        .pc        (pc),
        .link_addr (link_addr),
        .running   (running),
        .halted    (halted),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_running", {31'b0, running}, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        check("rst_link", link_addr, 32'h4);
        #10 rst_n = 1'b1;
        tick();

        // Straight-line program ending in a halt word
        load(8'd0, ADD_W);
        load(8'd1, ADD_W);
        load(8'd2, ADD_W);
        load(8'd3, HALT_W);
        check("idle_instr", instr, 32'h0);
        pulse_start();
        check("seq_run", {31'b0, running}, 32'd1);
        check("seq_pc0", pc, 32'h0);
        check("seq_instr0", instr, ADD_W);
        tick(); check("seq_pc4", pc, 32'h4);
        tick(); check("seq_pc8", pc, 32'h8);
        tick(); check("seq_pc12", pc, 32'hC);
        check("seq_instr_halt", instr, HALT_W);
        tick();
        check("seq_halted", {31'b0, halted}, 32'd1);
        check("seq_halt_pc", pc, 32'hC);
        check("seq_fault", {31'b0, fault}, 32'd0);
        check("halt_instr", instr, 32'h0);

        // beq at 8, taken then not taken
        load(8'd2, BEQ_W);
        pulse_start();
        tick(); tick();
        check("beq_pc", pc, 32'h8);
        zero = 1'b1;
        tick(); check("beq_taken", pc, 32'h4);
        zero = 1'b0;
        tick(); check("beq_back", pc, 32'h8);
        tick(); check("beq_not_taken", pc, 32'hC);
        tick(); check("beq_halted", {31'b0, halted}, 32'd1);

        // jal / jr, stall, load ignored in RUN
        load(8'd2, ADD_W);
        load(8'd3, ADD_W);
        load(8'd4, JAL_W);
        load(8'd5, HALT_W);
        load(8'd32, JR_W);
        pulse_start();
        load_en = 1'b1; load_addr = 8'd5; load_data = ADD_W;
        tick();
        load_en = 1'b0;
        tick();
        check("stall_pc_pre", pc, 32'h8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check("stall_pc", pc, 32'h8);
        end
        stall = 1'b0;
        tick(); tick();
        check("jal_pc", pc, 32'h10);
        check("jal_instr", instr, JAL_W);
        check("jal_link", link_addr, 32'h14);
        tick(); check("jal_target", pc, 32'h80);
        check("jr_link", link_addr, 32'h84);
        rs_data = 32'h14;
        tick(); check("jr_target", pc, 32'h14);
        check("run_load_ignored", instr, HALT_W);
        tick(); check("jr_halted", {31'b0, halted}, 32'd1);

        // Misaligned jr target
        pulse_start();
        for (int i = 0; i < 5; i++) tick();
        check("fault_jr_pc_pre", pc, 32'h80);
        rs_data = 32'h6;
        tick();
        check("fault_jr_halted", {31'b0, halted}, 32'd1);
        check("fault_jr_flag", {31'b0, fault}, 32'd1);
        check("fault_jr_pc", pc, 32'h80);
        rs_data = 32'h14;
        pulse_start();
        check("fault_clr", {31'b0, fault}, 32'd0);
        check("fault_clr_pc", pc, 32'h0);
        for (int i = 0; i < 6; i++) tick();
        check("fault_clr_pc_end", pc, 32'h14);
        tick(); check("fault_clr_halted", {31'b0, halted}, 32'd1);

        // Out-of-range j target
        load(8'd1, J300_W);
        pulse_start();
        tick(); check("j300_pc", pc, 32'h4);
        tick();
        check("j300_halted", {31'b0, halted}, 32'd1);
        check("j300_fault", {31'b0, fault}, 32'd1);
        check("j300_pc_hold", pc, 32'h4);
        pulse_start();
        check("j300_clr", {31'b0, fault}, 32'd0);
        check("j300_clr_pc", pc, 32'h0);
        tick(); tick();

        // Reset mid-run at 0x20, then start+load together in IDLE
        load(8'd1, J20_W);
        load(8'd8, ADD_W);
        pulse_start();
        tick(); tick();
        check("mid_pc", pc, 32'h20);
        check("mid_instr", instr, ADD_W);
        rst_n = 1'b0;
        #1;
        check("mid_rst_instr", instr, 32'h0);
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_running", {31'b0, running}, 32'd0);
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_idle", {31'b0, running}, 32'd0);
        start = 1'b1;
        load(8'd0, HALT_W);
        start = 1'b0;
        check("start_load_running", {31'b0, running}, 32'd0);
        check("start_load_halted", {31'b0, halted}, 32'd0);
        pulse_start();
        check("start_load_written", instr, HALT_W);
        tick();
        check("start_load_halt", {31'b0, halted}, 32'd1);
        check("start_load_pc", pc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit for the single-cycle MIPS-like core: holds the program counter, stores the program in a word-addressed instruction memory, and drives the 32-bit instruction word into the control decoder and register file every cycle. It computes the next PC from the current instruction's opcode, the ALU `zero` flag and the `rs` register value. A load port writes the program while the core is stopped. A small run-control FSM starts execution, halts it on a halt word, and reports faults.

## Interface
- `DEPTH`, 256: instruction memory depth in 32-bit words (power of two).
- `ADDR_W`, 8: word-index width; equals log2(`DEPTH`).
- `RESET_PC`, 32'h0000_0000: start address (byte address, word aligned).

Ports:
- `clk`  in  1  single clock; everything updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  pulse; begins execution from `RESET_PC`.
- `stall`  in  1  holds the PC in RUN.
- `load_en`  in  1  program write strobe.
- `load_addr`  in  ADDR_W  word index for the write.
- `load_data`  in  32  instruction word to write.
- `zero`  in  1  ALU zero flag for the current instruction.
- `rs_data`  in  32  rs register value, used as the jr target.
- `instr`  out  32  current instruction to decoder; 0 (nop) unless RUN.
- `pc`  out  32  current PC.
- `link_addr`  out  32  pc+4, written to $ra by jal.
- `running`  out  1  state == RUN.
- `halted`  out  1  state == HALT.
- `fault`  out  1  sticky fault flag; cleared by `start` or reset.

## Operation
- FSM states: IDLE, RUN, HALT. Reset enters IDLE.
- Reset values: `pc`=`RESET_PC`, `instr`=0, `running`=0, `halted`=0, `fault`=0. Memory contents are not affected by reset.
- IDLE and HALT:
  - `load_en` writes `load_data` to mem[`load_addr`] at the edge.
  - `start` without `load_en`: `pc`←`RESET_PC`, `fault`←0, go to RUN.
  - `start` together with `load_en`: the load is performed and `start` is ignored.
- RUN: `load_en` and `start` are ignored.
- RUN, `stall`=1: `pc` holds.
- RUN, `stall`=0: next PC is selected by opcode `instr[31:26]`:
  - 000100 beq: taken when `zero`=1, to pc+4+(sext(instr[15:0])<<2); otherwise pc+4.
  - 000010 j and 000011 jal: {pc+4[31:28], instr[25:0], 2'b00}.
  - 001000 jr: `rs_data`.
  - any other opcode: pc+4.
- Halt word: `instr`==32'hFFFF_FFFF in RUN moves the FSM to HALT at the next edge and `pc` holds. This takes priority over `stall`.
- Fault: if the selected target has bits [1:0]≠0, or its word index (bits [31:2]) is ≥`DEPTH`, the FSM goes to HALT with `fault`=1 and `pc` is not updated.
- Arithmetic is 32-bit modulo 2^32. Memory is indexed by pc[ADDR_W+1:2].
- `link_addr` is always pc+4, in every state.

## Timing
- `instr` is combinational from `pc` and the memory (asynchronous read). A write is visible to a read the cycle after the load edge.
- `pc`, the FSM state and `fault` update only on the rising edge of `clk`, except for the asynchronous assertion of `rst_n`.
- `start` in IDLE: RUN from the next edge; the first instruction is mem[`RESET_PC`>>2] in that cycle.
- Branch or jump in cycle n: the target instruction is on `instr` in cycle n+1. There are no delay slots.
- Reset asserted mid-RUN: immediately IDLE and `instr`=0. On release the core waits for `start`.

## Structure
- Package `mips_pkg` holds:
  - opcode constants OP_BEQ, OP_J, OP_JAL, OP_JR, and HALT_WORD;
  - the FSM state enum (IDLE/RUN/HALT).
  
  These constants are shared with the decoder.
- Sub-module `npc`: purely combinational. Inputs are pc, instr, zero and rs_data; outputs are next_pc and misaligned. `ifetch` adds the range check, the FSM, the PC register and the memory.

## Test plan
- Reset, then load words 0..3 with ADD, ADD, ADD, 32'hFFFF_FFFF, then `start` → pc steps 0, 4, 8, 12; `halted`=1 at cycle 4 with pc=12; `fault`=0.
- beq at address 8 with imm=16'hFFFE: `zero`=1 → next pc=4; `zero`=0 → next pc=12.
- jal at pc=0x10 with target field 26'h20 → `link_addr`=0x14 that cycle, next pc=0x80. jr with `rs_data`=0x14 → next pc=0x14.
- jr with `rs_data`=0x6 → HALT, `fault`=1, pc unchanged. j to word 300 with `DEPTH`=256 → same response. `start` then clears `fault` and pc=0.
- `stall`=1 for 3 cycles in RUN → pc constant. A `load_en` during RUN leaves the memory word unchanged.
- `rst_n` pulsed low mid-RUN at pc=0x20 → `instr`=0 and pc=`RESET_PC` immediately; `start` with `load_en` together in IDLE → write happens and the FSM stays IDLE.
